// File: rtl/adc_sample_packer.sv
// Packs 10-bit ADC samples MSB-first into a byte stream through a small
// first-word-fall-through FIFO, with capture windowing, overflow tracking and flush.
module adc_sample_packer #(
    parameter int FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  sample_i,
    input  logic        sample_valid_i,
    input  logic        capture_go_i,
    output logic [7:0]  byte_o,
    output logic        byte_valid_o,
    input  logic        byte_ready_i,
    output logic        overflow_o,
    output logic [31:0] byte_count_o,
    output logic        done_o
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t             state_q, state_d;
    logic [23:0]        acc_q, acc_d;
    logic [4:0]         level_q, level_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic               byte_valid_q, byte_valid_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;
    logic [31:0]        byte_count_q, byte_count_d;
    logic [7:0]         fifo_mem_q [DEPTH];

    logic               pop, space, push;
    logic               in_window, drop, accept;
    logic [4:0]         level_after;
    logic [23:0]        acc_shift;

    always_comb begin
        pop   = byte_valid_q && byte_ready_i;
        // Count never exceeds DEPTH, so its MSB alone flags a full FIFO.
        space = !count_q[FIFO_AW] || pop;
        push  = space && ((level_q >= 5'd8) ||
                          ((state_q == FLUSH) && (level_q != 5'd0)));

        level_after = level_q;
        acc_shift   = acc_q;
        if (push) begin
            level_after = (level_q >= 5'd8) ? (level_q - 5'd8) : 5'd0;
            acc_shift   = acc_q << 8;
        end

        // Bits below the level are always zero, so a partial flush byte is already padded.
        in_window = (state_q == RUN) && capture_go_i && sample_valid_i;
        drop      = in_window && (level_after > 5'd14);
        accept    = in_window && !drop;

        acc_d   = acc_shift;
        level_d = level_after;
        if (accept) begin
            acc_d   = acc_shift | ({14'd0, sample_i} << (5'd14 - level_after));
            level_d = level_after + 5'd10;
        end

        wr_ptr_d = push ? (wr_ptr_q + FIFO_AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + FIFO_AW'(1)) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
            default: count_d = count_q;
        endcase
        byte_valid_d = (count_d != '0);

        state_d      = state_q;
        done_d       = 1'b0;
        overflow_d   = overflow_q || drop;
        byte_count_d = push ? (byte_count_q + 32'd1) : byte_count_q;
        case (state_q)
            IDLE: begin
                if (capture_go_i) begin
                    state_d      = RUN;
                    overflow_d   = 1'b0;
                    byte_count_d = 32'd0;
                end
            end
            RUN: begin
                if (!capture_go_i) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (level_d == 5'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            acc_q        <= 24'd0;
            level_q      <= 5'd0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            byte_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
            byte_count_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            level_q      <= level_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            byte_valid_q <= byte_valid_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
            byte_count_q <= byte_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= acc_q[23:16];
        end
    end

    assign byte_o       = fifo_mem_q[rd_ptr_q];
    assign byte_valid_o = byte_valid_q;
    assign overflow_o   = overflow_q;
    assign byte_count_o = byte_count_q;
    assign done_o       = done_q;

endmodule

// File: doc/adc_sample_packer.md
ADC_SAMPLE_PACKER -- requirements
Module: adc_sample_packer

Interface
REQ-001 SHALL have parameter FIFO_AW, default 4, output byte FIFO address width (depth 2^FIFO_AW = 16 bytes).
REQ-002 SHALL have port clk  input  1  single clock, all logic rising-edge; driven by ADC_clk_sample.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port sample_i  input  10  ADC sample word.
REQ-005 SHALL have port sample_valid_i  input  1  sample_i valid this cycle.
REQ-006 SHALL have port capture_go_i  input  1  capture window from trigger logic; level, high while capturing.
REQ-007 SHALL have port byte_o  output  8  FIFO head byte, first-word fall-through.
REQ-008 SHALL have port byte_valid_o  output  1  FIFO not empty.
REQ-009 SHALL have port byte_ready_i  input  1  consumer pops the head byte when byte_valid_o=1.
REQ-010 SHALL have port overflow_o  output  1  sticky: at least one sample dropped in current capture.
REQ-011 SHALL have port byte_count_o  output  32  bytes pushed into FIFO in current capture.
REQ-012 SHALL have port done_o  output  1  one-cycle pulse when flush completes.

Function
REQ-013 SHALL implement states IDLE, RUN, FLUSH; IDLE->RUN on capture_go_i=1; RUN->FLUSH on capture_go_i=0; FLUSH->IDLE once accumulator is empty.
REQ-014 SHALL, on IDLE->RUN, clear overflow_o and byte_count_o; FIFO contents are retained.
REQ-015 SHALL accept a sample only in RUN with capture_go_i=1 and sample_valid_i=1; samples in IDLE/FLUSH or coincident with capture_go_i falling are ignored.
REQ-016 SHALL hold a 24-bit MSB-first bit accumulator with level counter 0..24; accepted samples append MSB-first after existing bits.
REQ-017 SHALL push the top 8 accumulator bits into the FIFO each cycle level>=8 and FIFO not full (max one push per cycle).
REQ-018 SHALL, when a push and an accepted sample occur in the same cycle, take the push from pre-sample bits; new level = level-8+10.
REQ-019 SHALL drop a valid in-window sample if (level after this cycle's push)+10 > 24; drop sets overflow_o=1 until next capture start; accumulator unchanged.
REQ-020 SHALL, in FLUSH with 1..7 bits left and FIFO not full, push them left-justified, zero-padded, as one byte; level->0.
REQ-021 SHALL pulse done_o=1 for exactly one cycle on the FLUSH->IDLE transition, including when level was already 0 on entry.
REQ-022 SHALL ignore capture_go_i rising while in FLUSH; re-evaluated in IDLE next cycle.
REQ-023 SHALL pop on byte_valid_o&byte_ready_i; pop and push in same cycle allowed when full (net count unchanged) and when empty (push only).
REQ-024 SHALL increment byte_count_o per push, wrapping 0xFFFFFFFF->0.
REQ-025 SHALL provide registered outputs; byte_o reflects head entry combinationally from FIFO storage only.

Reset
REQ-026 SHALL, while reset=1, force state IDLE, level 0, FIFO empty, byte_valid_o=0, overflow_o=0, byte_count_o=0, done_o=0; byte_o value undefined but stable.
REQ-027 SHALL, on reset mid-capture, discard all buffered bits and bytes; no done_o pulse.

Verification
REQ-028 SHALL pass: go=1, samples 0x3FF,0x000,0x2AA,0x155, ready=1 -> bytes 0xFF,0xC0,0x0A,0xA9,0x55; byte_count_o=5; overflow_o=0.
REQ-029 SHALL pass: go=1, single sample 0x3FF, then go=0 -> bytes 0xFF,0xC0 (padded); done_o one pulse after second push.
REQ-030 SHALL pass: ready=0, samples every 4th cycle -> 15 accepted (16 bytes FIFO, 22 bits held), 16th dropped, overflow_o=1; next go rise clears overflow_o and byte_count_o.
REQ-031 SHALL pass: FIFO full, ready=1 with pending level>=8 -> pop+push same cycle, byte_valid_o stays 1, no byte lost or duplicated.
REQ-032 SHALL pass: reset asserted mid-RUN with 12 bits buffered and 5 bytes queued -> byte_valid_o=0 immediately, no done_o, next capture output begins with new samples only.
REQ-033 SHALL pass: go=1 then go=0 with no samples -> zero bytes, done_o single pulse, byte_count_o=0.
